// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter: FSM states, access
// sizes, requester IDs, the latched read command and the alignment helper.
package dm_arb_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] SIZ_B = 2'b00;
  localparam logic [1:0] SIZ_H = 2'b01;
  localparam logic [1:0] SIZ_W = 2'b10;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int unsigned CMD_ADDR_W = 8;

  typedef struct packed {
    logic                  id;
    logic [CMD_ADDR_W-1:0] addr;
    logic [1:0]            siz;
    logic                  se;
  } cmd_t;

  // Half needs addr[0]=0, word (siz=1x) needs addr[1:0]=00.
  function automatic logic misaligned(input logic [1:0] siz, input logic [1:0] a_lo);
    logic m;
    m = 1'b0;
    if (siz[1] == SIZ_W[1]) begin
      m = (a_lo != 2'b00);
    end else if (siz == SIZ_H) begin
      m = a_lo[0];
    end else if (siz == SIZ_B) begin
      m = 1'b0;
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that was not granted last time.
module dm_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  // Winner selection.
  always_comb begin
    winner = 1'b0;
    valid  = req[0] | req[1];
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer sharing the CPU data RAM between the load/store
// unit and the debug loader. Optional alignment check: DM_ARB_ALIGN_CHECK_EN.
import dm_arb_pkg::*;

module dm_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [3:0]            siz,
  input  logic [1:0]            se,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_write,
  output logic [1:0]            ram_siz,
  output logic                  ram_se,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [1:0]            err
);

  localparam int unsigned CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cmd_t               cmd_q, cmd_d;

  logic               win_s;
  logic               win_valid_s;
  logic               mis_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [1:0]         sel_siz_s;
  logic               sel_we_s;
  logic               sel_se_s;
  logic [DATA_W-1:0]  sel_wdata_s;

  dm_rr_pick2 u_pick (
    .req    (req),
    .last   (last_q),
    .winner (win_s),
    .valid  (win_valid_s)
  );

  // Route the winning requester's command fields.
  always_comb begin
    if (win_s == REQ_CPU) begin
      sel_addr_s  = addr[ADDR_W-1:0];
      sel_siz_s   = siz[1:0];
      sel_we_s    = we[0];
      sel_se_s    = se[0];
      sel_wdata_s = wdata[DATA_W-1:0];
    end else begin
      sel_addr_s  = addr[2*ADDR_W-1:ADDR_W];
      sel_siz_s   = siz[3:2];
      sel_we_s    = we[1];
      sel_se_s    = se[1];
      sel_wdata_s = wdata[2*DATA_W-1:DATA_W];
    end
`ifdef DM_ARB_ALIGN_CHECK_EN
    mis_s = misaligned(sel_siz_s, sel_addr_s[1:0]);
`else
    mis_s = 1'b0;
`endif
  end

  // Next-state logic and RAM-side/requester-side outputs.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    gnt       = 2'b00;
    rvalid    = 2'b00;
    rdata     = '0;
    err       = 2'b00;
    ram_addr  = '0;
    ram_write = 1'b0;
    ram_siz   = 2'b00;
    ram_se    = 1'b0;
    ram_wdata = '0;
    // Outputs stay quiet while reset is held so an in-flight read is dropped.
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_s) begin
            gnt[win_s] = 1'b1;
            err[win_s] = mis_s;
            ram_addr   = sel_addr_s;
            ram_write  = sel_we_s & ~mis_s;
            ram_siz    = sel_siz_s;
            ram_se     = sel_se_s;
            ram_wdata  = sel_wdata_s;
            last_d     = win_s;
            if (!sel_we_s && !mis_s) begin
              cmd_d   = '{id: win_s, addr: CMD_ADDR_W'(sel_addr_s), siz: sel_siz_s, se: sel_se_s};
              cnt_d   = CNT_W'(1);
              state_d = RD_WAIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RD_WAIT: begin
          ram_addr = ADDR_W'(cmd_q.addr);
          ram_siz  = cmd_q.siz;
          ram_se   = cmd_q.se;
          if (cnt_q == CNT_W'(RD_LAT)) begin
            rvalid[cmd_q.id] = 1'b1;
            rdata            = ram_rdata;
            cnt_d            = '0;
            state_d          = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_DBG;
      cnt_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter/sequencer for the CPU data RAM (byte-addressed, 8-bit address, 1-cycle block-RAM read, byte/half/word size with sign-extension).
- Shares the RAM between requester 0 (CPU load/store unit) and requester 1 (debug/DMA loader).
- Uses round-robin arbitration and a req/gnt/rvalid handshake.
- Holds the read command stable while read data is in flight, so the RAM's size/sign-extension output logic sees a consistent address.

Parameters:
- ADDR_W, 8, byte address width (RAM word index is ADDR_W-2 bits).
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in clock edges (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  2  request, bit i = requester i; held until gnt
- we  in  2  1 = store, 0 = load
- addr  in  2*ADDR_W  byte address; slice i = requester i
- siz  in  4  2 bits per requester: 00 byte, 01 half, 1x word
- se  in  2  sign-extend loads
- wdata  in  2*DATA_W  store data, low bytes aligned
- gnt  out  2  one-cycle grant pulse; request accepted
- rvalid  out  2  one-cycle load-data-valid pulse
- rdata  out  DATA_W  load data, shared by both requesters, qualified by rvalid
- ram_addr  out  ADDR_W  to RAM address
- ram_write  out  1  to RAM write enable
- ram_siz  out  2  to RAM size
- ram_se  out  1  to RAM sign-extend select
- ram_wdata  out  DATA_W  to RAM write data
- ram_rdata  in  DATA_W  from RAM, already extended
- err  out  2  alignment error pulse; only with the optional feature, otherwise tied 0

Behaviour:
- FSM states: IDLE, RD_WAIT.
- Register cnt is wide enough for RD_LAT.
- Register last (1 bit) holds the previously granted requester.
- Register cmd holds id, addr, siz, se.
- Reset values: state=IDLE, last=1 (requester 0 wins the first tie), cnt=0, cmd=0; gnt=0, rvalid=0, ram_write=0, err=0.
- IDLE, arbitration:
  - Winner w is the single requester, or on a tie ~last. Grant is combinational in the same cycle: gnt[w]=1.
  - ram_* are driven combinationally from w's slices. ram_write=we[w].
  - On the clock edge: last<=w.
  - Store: stay in IDLE. Next access may be granted the following cycle, giving one store per cycle.
  - Load: cmd<=w's fields, cnt<=1, go to RD_WAIT.
- IDLE with no request: ram_write=0, ram_* = 0.
- RD_WAIT:
  - No grants. ram_write=0. ram_addr/siz/se driven from cmd.
  - If cnt==RD_LAT: rvalid[cmd.id]=1 and rdata=ram_rdata (combinational pass-through), then IDLE on the next edge. Otherwise cnt<=cnt+1.
- Load timing: gnt at cycle T, rvalid at T+RD_LAT. Next grant no earlier than T+RD_LAT+1.
- Fairness: with both requesters continuously requesting, grants alternate strictly 0,1,0,1…
- A request arriving during RD_WAIT waits and is arbitrated in the first IDLE cycle.
- rdata = 0 when no rvalid is asserted.
- Reset asserted mid-read: the read is discarded with no rvalid, and the block returns to IDLE. The requester must re-issue.
- A requester dropping req without gnt is legal; nothing is latched.

Optional Feature:
- Macro: DM_ARB_ALIGN_CHECK_EN.
- Defined:
  - A request is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]≠00.
  - A misaligned winner still receives gnt, and err[w] pulses in the same cycle.
  - A misaligned store forces ram_write=0.
  - A misaligned load does not enter RD_WAIT and produces no rvalid.
- Undefined: err tied 0; unaligned accesses pass to the RAM unchanged.

Decomposition:
- Package dm_arb_pkg holds:
  - state enum {IDLE, RD_WAIT}
  - size constants SIZ_B=2'b00, SIZ_H=2'b01, SIZ_W=2'b10
  - requester ID constants REQ_CPU=0, REQ_DBG=1
  - the cmd struct typedef
- One natural sub-module: dm_rr_pick2, a 2-way round-robin picker (req, last → winner, valid).

Test Plan:
- Single store: req[0]=1, we=1, addr=0x05, siz=00, wdata=0xAB at T → gnt[0] at T, ram_write=1, ram_addr=0x05. A load back of byte 0x05 with se=1 → rvalid[0] at T+1+RD_LAT, rdata=0xFFFFFFAB.
- Load hold: word load at 0x08 → ram_addr/siz/se remain 0x08/10/x through RD_WAIT. rvalid[0] exactly RD_LAT cycles after gnt. No gnt during the wait.
- Contention: req=2'b11 for 8 cycles, all stores, from reset → gnt sequence 0,1,0,1,0,1,0,1 and ram_write=1 every cycle.
- Request during wait: requester 1 raises req during requester 0's RD_WAIT → gnt[1] in the first cycle after rvalid[0].
- Reset mid-read: assert rst in RD_WAIT → no rvalid. After release: state IDLE, and a tie grants requester 0 first.
- With DM_ARB_ALIGN_CHECK_EN, half store at 0x03 → gnt and err pulse, ram_write=0, and RAM contents unchanged. Without the macro, the store is written.
